idma_lane_buffer: RTL and testbench
===================================

// Module: idma_lane_buffer
// PURPOSE
// - Byte-lane-decoupled buffer between the iDMA read task and the AXI Lite write task.
// - One independent FIFO per byte lane. The read side pushes shifted lanes; the write side
//   pops only the lanes in its strobe mask.
// - Lets read/write misalignment be absorbed: a 2-to-1 or 1-to-2 mapping of read/write beats.
// - Its outputs drive the write task's buffer_out_i / buffer_out_valid_i / buffer_out_ready_o.
// PARAMETERS
// - StrbWidth  16     number of byte lanes (= data width / 8); >= 1
// - Depth      3      entries per lane FIFO; >= 2; need not be a power of two
// - byte_t     logic  lane element type (8-bit)
// - strb_t     logic  StrbWidth-bit lane vector type
// PORTS
// - clk_i        in   1              clock
// - rst_i        in   1              reset: asynchronous, active-high
// - flush_i      in   1              synchronous clear of all lanes (datapath poison/abort)
// - in_data_i    in   StrbWidth*8    byte per lane from read side
// - in_valid_i   in   StrbWidth      per-lane push request
// - in_ready_o   out  StrbWidth      per-lane not-full
// - out_data_o   out  StrbWidth*8    head byte per lane
// - out_valid_o  out  StrbWidth      per-lane not-empty
// - out_ready_i  in   StrbWidth      per-lane pop (write-task mask when a write happens)
// - empty_o      out  1              all lanes empty (= &~out_valid_o)
// BEHAVIOUR
// - Per lane i: storage mem[Depth], rd_ptr/wr_ptr in [0,Depth-1], cnt in [0,Depth], width $clog2(Depth+1).
// - Pointers wrap from Depth-1 to 0 by explicit compare, never by overflow.
// - Push_i = in_valid_i[i] & in_ready_o[i]. Pop_i = out_valid_o[i] & out_ready_i[i].
// - in_ready_o[i] = (cnt != Depth). It depends on registered state only; there is no comb path from out_ready_i.
// - out_valid_o[i] = (cnt != 0); out_data_o[i] = mem[rd_ptr].
// - Latency: push in cycle N -> out_valid_o[i] high in N+1. No fall-through unless the macro below is set.
// - Counter update:
//   - push & ~pop -> cnt+1
//   - pop & ~push -> cnt-1
//   - both -> cnt unchanged; both pointers advance.
// - Full with out_ready_i high: pop occurs, push refused (in_ready_o=0 that cycle). Free slot seen in the next cycle.
// - Empty with out_ready_i high: no pop, no state change. An out_ready_i on an invalid lane is ignored.
// - Lanes are fully independent: cnt may differ per lane. Byte order within a lane is FIFO.
// - flush_i=1: next edge sets all ptr/cnt = 0. Pushes/pops in that cycle are discarded.
//   - in_ready_o stays as computed from cnt. The flush takes priority over push/pop.
// - Reset: while rst_i high and after release, ptr=cnt=0. Memory is not reset.
//   - out_valid_o='0, in_ready_o='1, empty_o=1, out_data_o=don't care (X allowed).
// - Reset asserted mid-transfer: state clears asynchronously and all buffered bytes are lost. No handshake completes.
// CONFIGURATION
// - IDMA_LANE_BUFFER_FALLTHROUGH_EN defined:
//   - out_valid_o[i] = (cnt!=0) | in_valid_i[i].
//   - When cnt==0, out_data_o[i] = in_data_i[i].
//   - Push+pop on an empty lane passes the byte through without storing it; cnt stays 0.
//   - Adds a comb path in_valid_i/in_data_i -> out_*. Latency is 0.
// - Undefined (default): registered-only outputs, latency 1, as above.
// TESTING
// - Reset, then idle: out_valid_o=16'h0000, in_ready_o=16'hFFFF, empty_o=1.
// - Push lane0 0xA1,0xA2,0xA3 on consecutive cycles with out_ready_i=0:
//   - in_ready_o[0]=0 after the 3rd push.
//   - Pop 3x -> out_data_o[0] = 0xA1,0xA2,0xA3, then out_valid_o[0]=0.
// - Misaligned beat: push in_valid_i=16'hFFF0, then 16'h000F.
//   - Pop mask 16'hFFFF only when out_valid_o=16'hFFFF (cycle after 2nd push); all lanes empty after.
// - Full lane5 with in_valid_i[5]=1 and out_ready_i[5]=1 same cycle: one pop, no push.
//   - cnt 3->2, and in_ready_o[5]=1 next cycle.
// - Lane2 cnt=2; assert flush_i with push+pop on lane2 -> next cycle out_valid_o[2]=0, empty_o=1.
// - Assert rst_i asynchronously mid-cycle with 8 lanes holding data -> out_valid_o='0 before the next clk edge.
//   - With FALLTHROUGH_EN: empty lane7 push 0x5C & pop -> out_data_o[7]=0x5C same cycle, cnt stays 0.

Source files
------------

// File: rtl/idma_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module      : idma_lane_buffer
// Description : Per-byte-lane FIFOs between the iDMA read and AXI Lite write
//               tasks. Optional macro IDMA_LANE_BUFFER_FALLTHROUGH_EN turns
//               on zero-latency pass-through on empty lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module idma_lane_buffer #(
    parameter int unsigned StrbWidth = 16,
    parameter int unsigned Depth     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [StrbWidth*8-1:0] in_data_i,
    input  logic [StrbWidth-1:0]   in_valid_i,
    output logic [StrbWidth-1:0]   in_ready_o,
    output logic [StrbWidth*8-1:0] out_data_o,
    output logic [StrbWidth-1:0]   out_valid_o,
    input  logic [StrbWidth-1:0]   out_ready_i,
    output logic                   empty_o
);

    typedef logic [7:0] byte_t;

    localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_cnt_w = $clog2(Depth + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(Depth - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(Depth);

    assign empty_o = &(~out_valid_o);

    for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
        byte_t              r_mem [Depth];
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_cnt_w-1:0] r_cnt;
        byte_t              w_in_byte;
        logic               w_out_valid;
        logic               w_bypass;
        logic               w_push;
        logic               w_pop;
        logic               w_store;
        logic               w_take;

        assign w_in_byte     = in_data_i[i*8 +: 8];
        assign in_ready_o[i] = (r_cnt != c_depth);

`ifdef IDMA_LANE_BUFFER_FALLTHROUGH_EN
        // Empty lane: the incoming byte is presented directly and, if popped
        // in the same cycle, never touches storage.
        assign w_out_valid             = (r_cnt != '0) | in_valid_i[i];
        assign w_bypass                = (r_cnt == '0) & in_valid_i[i] & out_ready_i[i];
        assign out_data_o[i*8 +: 8]    = (r_cnt == '0) ? w_in_byte : r_mem[r_rd_ptr];
`else
        assign w_out_valid             = (r_cnt != '0);
        assign w_bypass                = 1'b0;
        assign out_data_o[i*8 +: 8]    = r_mem[r_rd_ptr];
`endif

        assign out_valid_o[i] = w_out_valid;
        assign w_push         = in_valid_i[i] & in_ready_o[i];
        assign w_pop          = w_out_valid & out_ready_i[i];
        assign w_store        = w_push & ~w_bypass;
        assign w_take         = w_pop & ~w_bypass;

        // Storage carries no reset; only pointers and count define validity.
        always_ff @(posedge clk_i) begin
            if (w_store && !flush_i) begin
                r_mem[r_wr_ptr] <= w_in_byte;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_take) begin
                    r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                end
                if (w_store && !w_take) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_take && !w_store) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idma_lane_buffer.sv
`default_nettype none
// Directed-vector bench for idma_lane_buffer (16 lanes, depth 3).
module tb_idma_lane_buffer;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [127:0] in_data;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic [127:0] out_data;
    logic [15:0]  out_valid;
    logic [15:0]  out_ready;
    logic         empty;

    int n_vec = 0;
    int n_err = 0;

    idma_lane_buffer #(.StrbWidth(16), .Depth(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .empty_o     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '0;
        step();
        step();
        rst = 1'b0;
        step();

        check("rst_out_valid", 128'(out_valid), 128'h0000);
        check("rst_in_ready",  128'(in_ready),  128'hFFFF);
        check("rst_empty",     128'(empty),     128'h1);

        // Lane 0: fill to depth, then drain in order
        in_valid = 16'h0001;
        in_data[7:0] = 8'hA1; step();
        in_data[7:0] = 8'hA2; step();
        in_data[7:0] = 8'hA3; step();
        in_valid = '0;
        check("l0_full_ready", 128'(in_ready[0]),  128'h0);
        check("l0_valid",      128'(out_valid),    128'h0001);
        out_ready = 16'h0001;
        check("l0_pop1", 128'(out_data[7:0]), 128'hA1); step();
        check("l0_ready_after_pop", 128'(in_ready[0]), 128'h1);
        check("l0_pop2", 128'(out_data[7:0]), 128'hA2); step();
        check("l0_pop3", 128'(out_data[7:0]), 128'hA3); step();
        out_ready = '0;
        check("l0_drained", 128'(out_valid[0]), 128'h0);
        check("l0_empty",   128'(empty),        128'h1);

        // Misaligned beat: upper lanes then lower lanes
        in_data  = 128'h1F1E1D1C1B1A19181716151413121110;
        in_valid = 16'hFFF0;
        step();
        in_valid = 16'h000F;
`ifdef IDMA_LANE_BUFFER_FALLTHROUGH_EN
        check("mis_valid_mid", 128'(out_valid), 128'hFFFF);
`else
        check("mis_valid_mid", 128'(out_valid), 128'hFFF0);
`endif
        step();
        in_valid = '0;
        check("mis_valid_full", 128'(out_valid), 128'hFFFF);
        check("mis_data",       out_data, 128'h1F1E1D1C1B1A19181716151413121110);
        out_ready = 16'hFFFF;
        step();
        out_ready = '0;
        check("mis_drained", 128'(out_valid), 128'h0000);
        check("mis_empty",   128'(empty),     128'h1);

        // Lane 5 full with simultaneous push and pop
        in_valid = 16'h0020;
        in_data[47:40] = 8'h51; step();
        in_data[47:40] = 8'h52; step();
        in_data[47:40] = 8'h53; step();
        in_data[47:40] = 8'h54;
        out_ready = 16'h0020;
        check("l5_full_ready", 128'(in_ready[5]), 128'h0);
        check("l5_head",       128'(out_data[47:40]), 128'h51);
        step();
        in_valid  = '0;
        out_ready = '0;
        check("l5_ready_next", 128'(in_ready[5]),     128'h1);
        check("l5_head_next",  128'(out_data[47:40]), 128'h52);
        out_ready = 16'h0020;
        step();
        check("l5_last", 128'(out_data[47:40]), 128'h53);
        step();
        out_ready = '0;
        check("l5_drained", 128'(out_valid[5]), 128'h0);

        // Lane 2 flush overrides push and pop
        in_valid = 16'h0004;
        in_data[23:16] = 8'h21; step();
        in_data[23:16] = 8'h22; step();
        flush     = 1'b1;
        out_ready = 16'h0004;
        in_data[23:16] = 8'h23;
        step();
        flush     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        check("flush_valid2", 128'(out_valid[2]), 128'h0);
        check("flush_empty",  128'(empty),        128'h1);
        check("flush_ready",  128'(in_ready),     128'hFFFF);

        // Asynchronous reset with eight lanes loaded
        in_valid = 16'h00FF;
        in_data  = 128'h0000000000000000_0102030405060708;
        step();
        in_valid = '0;
        check("ar_loaded", 128'(out_valid), 128'h00FF);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid",    128'(out_valid), 128'h0000);
        check("ar_in_ready", 128'(in_ready),  128'hFFFF);
        check("ar_empty",    128'(empty),     128'h1);
        step();
        rst = 1'b0;
        step();

        // Lane 7: push and pop together on an empty lane
        in_valid  = 16'h0080;
        out_ready = 16'h0080;
        in_data[63:56] = 8'h5C;
        #1;
`ifdef IDMA_LANE_BUFFER_FALLTHROUGH_EN
        check("ft_valid_same", 128'(out_valid[7]),    128'h1);
        check("ft_data_same",  128'(out_data[63:56]), 128'h5C);
        step();
        in_valid  = '0;
        out_ready = '0;
        check("ft_cnt_zero", 128'(out_valid), 128'h0000);
`else
        check("nf_valid_same", 128'(out_valid[7]), 128'h0);
        step();
        in_valid  = '0;
        out_ready = '0;
        check("nf_valid_next", 128'(out_valid[7]),    128'h1);
        check("nf_data_next",  128'(out_data[63:56]), 128'h5C);
        out_ready = 16'h0080;
        step();
        out_ready = '0;
        check("nf_drained", 128'(out_valid), 128'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
